dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/y86_mem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 41 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared Y86 memory-side definitions: processor status codes, responder FSM
// encodings and quadword geometry used by dmem_responder and dmem_array.
package y86_mem_pkg;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int QWORD_BYTES = 8;
  localparam int QWORD_W     = 8 * QWORD_BYTES;
  localparam int CNT_W       = 4;

  // Status the processor should record for a completed data access.
  function automatic stat_e rsp_status(input logic addr_error);
    return addr_error ? STAT_ADR : STAT_AOK;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data storage with a combinational 8-byte little-endian read
// port and an 8-byte write port sharing one address. Contents are never reset.
module dmem_array
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int AW        = 12
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [QWORD_W-1:0] wdata,
  output logic [QWORD_W-1:0] rdata
);

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] idx   [QWORD_BYTES];

  always_comb begin
    for (int i = 0; i < QWORD_BYTES; i++) begin
      idx[i] = addr + AW'(i);
    end
  end

  // Byte at the base address lands in the least significant lane.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < QWORD_BYTES; i++) begin
      rdata[8*i +: 8] = mem_q[idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < QWORD_BYTES; i++) begin
        mem_q[idx[i]] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency quadword data-memory responder for the Y86 memory stage.
// Optional build macro DMEM_ALIGN_CHECK_EN also flags addresses not 8-byte aligned.
module dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  dmem_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [63:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               error_q, error_d;

  logic [64:0]        end_addr;
  logic               range_err;
  logic               addr_err;
  logic               mem_we;
  logic [63:0]        mem_rdata;

  // Last byte computed one bit wider so addresses near 2^64 cannot wrap into range.
  always_comb begin
    end_addr  = {1'b0, addr_q} + 65'(QWORD_BYTES - 1);
    range_err = (end_addr >= 65'(MEM_BYTES));
`ifdef DMEM_ALIGN_CHECK_EN
    addr_err  = range_err | (addr_q[2:0] != 3'd0);
`else
    addr_err  = range_err;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_BUSY;
          cnt_d   = LAT_LOAD;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          error_d = addr_err;
          rdata_d = (write_q || addr_err) ? 64'd0 : mem_rdata;
          mem_we  = write_q & ~addr_err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 64'd0;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Request payload only matters once the FSM has left IDLE, so it needs no reset.
  always_ff @(posedge clock) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .clk   (clock),
    .we    (mem_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (MEM_BYTES=4096, LATENCY=2); expectations
// for unaligned accesses follow the DMEM_ALIGN_CHECK_EN build macro.
module tb_dmem_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  int total;
  int fails;

  dmem_responder #(
    .MEM_BYTES (4096),
    .LATENCY   (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge where rsp_valid is seen.
  task automatic issue(input logic wr, input logic [63:0] a, input logic [63:0] d,
                       output int lat);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input logic wr, input logic [63:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic er, output int lat);
    issue(wr, a, d, lat);
    rd = rsp_rdata;
    er = rsp_error;
    consume();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          seen;

    total = 0;
    fails = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clock);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);

    // Known contents for the neighbouring quadwords used below.
    txn(1'b1, 64'h18, 64'h0, rd, er, lat);
    check("init18_err", {63'd0, er}, 64'd0);
    txn(1'b1, 64'hFF8, 64'h0102030405060708, rd, er, lat);
    check("initff8_err", {63'd0, er}, 64'd0);

    txn(1'b1, 64'h10, 64'h1122334455667788, rd, er, lat);
    check("st10_lat", 64'(lat), 64'd2);
    check("st10_err", {63'd0, er}, 64'd0);
    check("st10_rdata", rd, 64'd0);

    txn(1'b0, 64'h10, 64'h0, rd, er, lat);
    check("ld10_lat", 64'(lat), 64'd2);
    check("ld10_err", {63'd0, er}, 64'd0);
    check("ld10_rdata", rd, 64'h1122334455667788);

    txn(1'b0, 64'h11, 64'h0, rd, er, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    check("ld11_err", {63'd0, er}, 64'd1);
    check("ld11_rdata", rd, 64'd0);
`else
    check("ld11_err", {63'd0, er}, 64'd0);
    check("ld11_rdata", rd, 64'h0011223344556677);
`endif

    txn(1'b1, 64'hFFC, 64'hDEADBEEFCAFEF00D, rd, er, lat);
    check("stffc_err", {63'd0, er}, 64'd1);
    check("stffc_rdata", rd, 64'd0);
    txn(1'b0, 64'hFF8, 64'h0, rd, er, lat);
    check("ldff8_err", {63'd0, er}, 64'd0);
    check("ldff8_unchanged", rd, 64'h0102030405060708);
    txn(1'b0, 64'hFF9, 64'h0, rd, er, lat);
    check("ldff9_err", {63'd0, er}, 64'd1);
    check("ldff9_rdata", rd, 64'd0);
    txn(1'b0, 64'hFFFFFFFFFFFFFFFC, 64'h0, rd, er, lat);
    check("ldwrap_err", {63'd0, er}, 64'd1);
    check("ldwrap_rdata", rd, 64'd0);
    txn(1'b0, 64'h0, 64'h0, rd, er, lat);
    check("ld0_err", {63'd0, er}, 64'd0);

    // Response held under back-pressure; a store presented meanwhile must be ignored.
    issue(1'b0, 64'h10, 64'h0, lat);
    check("hold_lat", 64'(lat), 64'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h10;
        req_wdata = 64'hFFFFFFFFFFFFFFFF;
      end
      check("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_rsp_rdata", rsp_rdata, 64'h1122334455667788);
      check("hold_rsp_error", {63'd0, rsp_error}, 64'd0);
      check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clock);
    end
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    consume();
    check("rel_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rel_req_ready", {63'd0, req_ready}, 64'd1);
    check("rel_rsp_rdata", rsp_rdata, 64'd0);
    check("rel_rsp_error", {63'd0, rsp_error}, 64'd0);
    txn(1'b0, 64'h10, 64'h0, rd, er, lat);
    check("ignored_store", rd, 64'h1122334455667788);

    // Reset one cycle after accepting a store: nothing commits, nothing responds.
    txn(1'b1, 64'h20, 64'h5555555555555555, rd, er, lat);
    check("init20_err", {63'd0, er}, 64'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'hAA;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_req_ready", {63'd0, req_ready}, 64'd0);
    check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);
    check("midrst_req_ready_after", {63'd0, req_ready}, 64'd1);
    txn(1'b0, 64'h20, 64'h0, rd, er, lat);
    check("midrst_old_data", rd, 64'h5555555555555555);
    check("midrst_ld_err", {63'd0, er}, 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
